// File: rtl/pd_deser.sv
// Serial-to-parallel reader for the 1-bit pd pipe: gathers LSB-first bits into
// WIDTH-bit words on a registered valid/ready port. Define PD_DESER_PARITY_EN for a trailing even-parity bit and o_perr.
module pd_deser #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pvld,
  input  logic             in_pd,
  output logic             in_prdy,
  output logic             o_pvld,
  output logic [WIDTH-1:0] o_pd,
  input  logic             o_prdy
`ifdef PD_DESER_PARITY_EN
  ,
  output logic             o_perr
`endif
);

`ifdef PD_DESER_PARITY_EN
  localparam int LAST_I = WIDTH;
`else
  localparam int LAST_I = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] next_word;
  logic             in_beat;
  logic             last_beat;

  // Handshake: a beat happens on any edge where valid & ready are both high.
  // Only the final bit of a word can stall, and only while the output holds an undrained word.
  assign in_prdy   = rst & ((bit_cnt != LAST) | ~o_pvld | o_prdy);
  assign in_beat   = in_pvld & in_prdy;
  assign last_beat = in_beat & (bit_cnt == LAST);

  // The parity beat (bit_cnt == WIDTH) matches no data position, so it leaves the word untouched.
  always_comb begin
    next_word = sreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_cnt == CNT_W'(i)) next_word[i] = in_pd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt <= '0;
      sreg    <= '0;
      o_pvld  <= 1'b0;
      o_pd    <= '0;
`ifdef PD_DESER_PARITY_EN
      o_perr  <= 1'b0;
`endif
    end else begin
      if (in_beat) begin
        sreg    <= next_word;
        bit_cnt <= last_beat ? '0 : bit_cnt + 1'b1;
      end
      if (last_beat) begin
        o_pvld <= 1'b1;
        o_pd   <= next_word;
`ifdef PD_DESER_PARITY_EN
        o_perr <= (^sreg) ^ in_pd;
`endif
      end else if (o_prdy) begin
        o_pvld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pd_deser.sv
// Bench for pd_deser: reset, table-driven words with mid-word gaps, hand corner cases,
// and randomized traffic against a bit-queue reference model with an expected-word scoreboard.
module tb_pd_deser;
  localparam int WIDTH = 8;
  localparam int CNT_W = 6;
`ifdef PD_DESER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic             clk;
  logic             rst;
  logic             in_pvld;
  logic             in_pd;
  logic             in_prdy;
  logic             o_pvld;
  logic [WIDTH-1:0] o_pd;
  logic             o_prdy;
`ifdef PD_DESER_PARITY_EN
  logic             o_perr;
`endif

  pd_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_pvld (in_pvld),
    .in_pd   (in_pd),
    .in_prdy (in_prdy),
    .o_pvld  (o_pvld),
    .o_pd    (o_pd),
    .o_prdy  (o_prdy)
`ifdef PD_DESER_PARITY_EN
    ,
    .o_perr  (o_perr)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: partial word as a queue of received bits plus the output register
  logic             part_q[$];
  logic             mv = 1'b0;
  logic [WIDTH-1:0] mw = '0;
  logic             mperr = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] data;
    int               gap;
    logic [WIDTH-1:0] exp_pd;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_bit(input logic [WIDTH-1:0] w, input int i);
    if (i < WIDTH) return w[i];
    return ^w;
  endfunction

  // One clock: drive, compare against the model, take the edge, advance the model.
  task automatic cyc(input logic pvld, input logic pd, input logic prdy);
    logic             exp_rdy;
    logic             done;
    logic [WIDTH-1:0] w;
    logic             p;
    in_pvld = pvld;
    in_pd   = pd;
    o_prdy  = prdy;
    #1;
    exp_rdy = rst && ((part_q.size() != NB - 1) || !mv || prdy);
    check("in_prdy", in_prdy, exp_rdy);
    check("o_pvld", o_pvld, mv);
    if (mv) begin
      check("o_pd", o_pd, mw);
`ifdef PD_DESER_PARITY_EN
      check("o_perr", o_perr, mperr);
`endif
    end
    if (o_pvld && prdy) begin
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("sb_word", o_pd, w);
      end
    end
    @(posedge clk);
    if (!rst) begin
      part_q.delete();
      exp_q.delete();
      mv = 1'b0;
      mw = '0;
      mperr = 1'b0;
    end else begin
      done = 1'b0;
      if (pvld && exp_rdy) begin
        part_q.push_back(pd);
        if (part_q.size() == NB) begin
          w = '0;
          p = 1'b0;
          for (int i = 0; i < NB; i++) begin
            if (i < WIDTH) w = w + (WIDTH'(part_q[i]) << i);
            p = p ^ part_q[i];
          end
          part_q.delete();
          mv = 1'b1;
          mw = w;
          mperr = p;
          exp_q.push_back(w);
          done = 1'b1;
        end
      end
      if (!done && mv && prdy) mv = 1'b0;
    end
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic prdy);
    for (int i = 0; i < NB; i++) cyc(1'b1, get_bit(w, i), prdy);
  endtask

  initial begin
    int pulses;
    rst = 1'b0; in_pvld = 1'b1; in_pd = 1'b1; o_prdy = 1'b0;

    // reset held two clocks with in_pvld high
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_prdy", in_prdy, 0);
    check("rst_o_pvld", o_pvld, 0);
    check("rst_o_pd", o_pd, 0);
    cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);

    // single word A5 with o_prdy high: one-cycle pulse one clock after the last bit
    send_word(8'hA5, 1'b1);
    check("a5_pvld", o_pvld, 1);
    check("a5_pd", o_pd, 8'hA5);
    cyc(1'b0, 1'b0, 1'b1);
    check("a5_pulse_end", o_pvld, 0);

    // back-to-back A5, 3C: no bubbles, two pulses
    pulses = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NB; i++) begin
        cyc(1'b1, get_bit(k == 0 ? 8'hA5 : 8'h3C, i), 1'b1);
        if (o_pvld) pulses++;
      end
    end
    cyc(1'b0, 1'b0, 1'b1);
    if (o_pvld) pulses++;
    check("b2b_pulses", pulses, 2);

    // A5 held, 3C's non-final bits accepted, final bit stalls until drain
    send_word(8'hA5, 1'b0);
    for (int i = 0; i < NB - 1; i++) cyc(1'b1, get_bit(8'h3C, i), 1'b0);
    cyc(1'b1, get_bit(8'h3C, NB - 1), 1'b0);
    check("hold_in_prdy", in_prdy, 0);
    check("hold_o_pd", o_pd, 8'hA5);
    cyc(1'b1, get_bit(8'h3C, NB - 1), 1'b1);
    check("swap_pvld", o_pvld, 1);
    check("swap_pd", o_pd, 8'h3C);
    cyc(1'b0, 1'b0, 1'b1);

    // reset mid-word discards the partial bits
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    check("midrst_pvld", o_pvld, 0);
    send_word(8'hFF, 1'b1);
    check("midrst_pvld2", o_pvld, 1);
    check("midrst_pd", o_pd, 8'hFF);
    cyc(1'b0, 1'b0, 1'b1);

`ifdef PD_DESER_PARITY_EN
    for (int i = 0; i < WIDTH; i++) cyc(1'b1, get_bit(8'hA5, i), 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    check("par_ok_perr", o_perr, 0);
    for (int i = 0; i < WIDTH; i++) cyc(1'b1, get_bit(8'hA5, i), 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    check("par_bad_perr", o_perr, 1);
    check("par_bad_pd", o_pd, 8'hA5);
    cyc(1'b0, 1'b0, 1'b1);
`endif

    // table: words with an idle gap (garbage in_pd) after bit 3
    vecs[0] = '{data: 8'hA5, gap: 0, exp_pd: 8'hA5};
    vecs[1] = '{data: 8'h3C, gap: 2, exp_pd: 8'h3C};
    vecs[2] = '{data: 8'h00, gap: 1, exp_pd: 8'h00};
    vecs[3] = '{data: 8'hFF, gap: 3, exp_pd: 8'hFF};
    vecs[4] = '{data: 8'h81, gap: 5, exp_pd: 8'h81};
    foreach (vecs[v]) begin
      for (int j = 0; j < NB; j++) begin
        if (j == 4) repeat (vecs[v].gap) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        cyc(1'b1, get_bit(vecs[v].data, j), 1'b1);
      end
      check("tbl_pvld", o_pvld, 1);
      check("tbl_pd", o_pd, vecs[v].exp_pd);
      cyc(1'b0, 1'b0, 1'b1);
    end

    // randomized traffic with occasional reset
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end
    rst = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    check("final_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
